absorb_loader: RTL and testbench

Upstream feeder for the sponge absorb stage. It packs a stream of BWIDTH-bit message words into NUMBLOCKS-word block vectors and zero-fills unused bytes of the final block. It also produces the per-block finalize, domain and byte-count side information. Each packed block is handed downstream over a valid/ready handshake, and the absorb controller pulses `blk_ready` when it has consumed the block.

---
 rtl/absorb_loader.sv | 140 ++++++++++++++
 tb/tb_absorb_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/absorb_loader.sv
// rtl/absorb_loader.sv - packs message words into sponge absorb blocks
//
// Purpose: collects up to NUMBLOCKS words of BWIDTH bits into one block,
// zero-fills bytes past the end of the message, and hands the block plus
// finalize/domain/byte-count side information downstream over a
// valid/ready handshake.
//
// Ports:
//   clk, reset                   clock (rising edge), async active-high reset
//   in_data/in_valid/in_last     message word stream
//   in_bytes                     valid low-order bytes of the last word
//   in_ready                     word accepted this cycle when in_valid
//   cfg_domain                   domain separator, latched at first word
//   blocks                       packed block, word k at [k*BWIDTH +: BWIDTH]
//   blk_valid/blk_ready          block handshake
//   finalize, domain             block carries last word / block domain
//   blk_bytes, partial           valid bytes in block / block not full
//
// Build option: ABSORB_LOADER_BYTESWAP_EN byte-reverses each word before
// masking; the valid bytes of a last word are then the high-order ones.

module absorb_loader #(
    parameter int BWIDTH    = 32,
    parameter int NUMBLOCKS = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [BWIDTH-1:0]                        in_data,
    input  logic                                     in_valid,
    input  logic                                     in_last,
    input  logic [$clog2(BWIDTH/8):0]                in_bytes,
    output logic                                     in_ready,
    input  logic [1:0]                               cfg_domain,
    output logic [BWIDTH*NUMBLOCKS-1:0]              blocks,
    output logic                                     blk_valid,
    input  logic                                     blk_ready,
    output logic                                     finalize,
    output logic [1:0]                               domain,
    output logic [$clog2(BWIDTH*NUMBLOCKS/8):0]      blk_bytes,
    output logic                                     partial
);

    localparam int BPW  = BWIDTH / 8;
    localparam int IB_W = $clog2(BPW) + 1;
    localparam int BB_W = $clog2(BPW * NUMBLOCKS) + 1;
    localparam int WC_W = $clog2(NUMBLOCKS + 1);

    localparam logic [IB_W-1:0] WORD_IB    = IB_W'(BPW);
    localparam logic [BB_W-1:0] MAX_BYTES  = BB_W'(BPW * NUMBLOCKS);
    localparam logic [WC_W-1:0] LAST_SLOT  = WC_W'(NUMBLOCKS - 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t            state, state_next;
    logic [WC_W-1:0]   wcnt;
    logic              accept;
    logic              transfer;
    logic              closing;
    logic [IB_W-1:0]   nbytes;
    logic [BB_W-1:0]   bytes_sum;
    logic [BWIDTH-1:0] word_src;
    logic [BWIDTH-1:0] word_masked;

    assign accept    = in_valid && (state == FILL);
    assign transfer  = blk_ready && (state == HOLD);
    assign closing   = accept && (in_last || wcnt == LAST_SLOT);
    assign in_ready  = (state == FILL);
    assign blk_valid = (state == HOLD);

    // Non-last words count as full; oversize byte counts saturate.
    always_comb begin
        nbytes = WORD_IB;
        if (in_last && in_bytes < WORD_IB)
            nbytes = in_bytes;
    end

    assign bytes_sum = blk_bytes + BB_W'(nbytes);

    always_comb begin
        word_src    = in_data;
        word_masked = '0;
`ifdef ABSORB_LOADER_BYTESWAP_EN
        for (int i = 0; i < BPW; i++)
            word_src[i*8 +: 8] = in_data[(BPW-1-i)*8 +: 8];
        // After the swap the message bytes occupy the top of the word.
        for (int i = 0; i < BPW; i++)
            if (IB_W'(i) + nbytes >= WORD_IB)
                word_masked[i*8 +: 8] = word_src[i*8 +: 8];
`else
        for (int i = 0; i < BPW; i++)
            if (IB_W'(i) < nbytes)
                word_masked[i*8 +: 8] = word_src[i*8 +: 8];
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= FILL;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL: if (closing)   state_next = HOLD;
            HOLD: if (blk_ready) state_next = FILL;
            default:             state_next = FILL;
        endcase
    end

    // Clearing the whole buffer on transfer keeps unfilled slots at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blocks    <= '0;
            wcnt      <= '0;
            blk_bytes <= '0;
            finalize  <= 1'b0;
            domain    <= 2'b00;
            partial   <= 1'b0;
        end else if (transfer) begin
            blocks    <= '0;
            wcnt      <= '0;
            blk_bytes <= '0;
            finalize  <= 1'b0;
            partial   <= 1'b0;
        end else if (accept) begin
            blocks[wcnt*BWIDTH +: BWIDTH] <= word_masked;
            wcnt      <= wcnt + 1'b1;
            blk_bytes <= bytes_sum;
            if (wcnt == '0)
                domain <= cfg_domain;
            if (closing) begin
                finalize <= in_last;
                partial  <= (bytes_sum < MAX_BYTES);
            end
        end
    end

endmodule

// File: tb/tb_absorb_loader.sv
// tb/tb_absorb_loader.sv - directed self-checking bench for absorb_loader

module tb_absorb_loader;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [2:0]   in_bytes = '0;
    logic         in_ready;
    logic [1:0]   cfg_domain = '0;
    logic [127:0] blocks;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic         finalize;
    logic [1:0]   domain;
    logic [4:0]   blk_bytes;
    logic         partial;

    int n_checks = 0;
    int n_fail   = 0;

    absorb_loader #(.BWIDTH(32), .NUMBLOCKS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_bytes   (in_bytes),
        .in_ready   (in_ready),
        .cfg_domain (cfg_domain),
        .blocks     (blocks),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .finalize   (finalize),
        .domain     (domain),
        .blk_bytes  (blk_bytes),
        .partial    (partial)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer a word at the falling edge, wait for in_ready, return #1 after the accept edge.
    task automatic send(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int waited = 0;
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        in_bytes = nb;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("send_timeout", 128'd0, 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take();
        blk_ready = 1'b1;
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
        check("post_xfer_valid", blk_valid, 1'b0);
        check("post_xfer_ready", in_ready, 1'b1);
        check("post_xfer_blocks", blocks, 128'd0);
        check("post_xfer_bytes", blk_bytes, 5'd0);
    endtask

    logic [127:0] held;

    initial begin
        #12;
        check("rst_ready", in_ready, 1'b1);
        check("rst_valid", blk_valid, 1'b0);
        check("rst_blocks", blocks, 128'd0);
        check("rst_bytes", blk_bytes, 5'd0);
        check("rst_partial", partial, 1'b0);
        check("rst_final", finalize, 1'b0);
        check("rst_domain", domain, 2'd0);
        @(negedge clk);
        reset = 1'b0;

        // Full block, last word exactly full.
        send(32'h11111111, 1'b0, 3'd0);
        send(32'h22222222, 1'b0, 3'd0);
        send(32'h33333333, 1'b0, 3'd0);
        check("full_early_valid", blk_valid, 1'b0);
        send(32'h44444444, 1'b1, 3'd4);
        check("full_valid", blk_valid, 1'b1);
        check("full_ready", in_ready, 1'b0);
        check("full_blocks", blocks, 128'h44444444_33333333_22222222_11111111);
        check("full_final", finalize, 1'b1);
        check("full_bytes", blk_bytes, 5'd16);
        check("full_partial", partial, 1'b0);
        take();

        // Partial last word.
        send(32'hAABBCCDD, 1'b0, 3'd0);
        send(32'h12345678, 1'b1, 3'd2);
        check("part_valid", blk_valid, 1'b1);
        check("part_blocks", blocks, {64'd0, 32'h00005678, 32'hAABBCCDD});
        check("part_bytes", blk_bytes, 5'd6);
        check("part_partial", partial, 1'b1);
        check("part_final", finalize, 1'b1);
        take();

        // Three-byte last word (byte order depends on the build option).
        send(32'h01020304, 1'b1, 3'd3);
`ifdef ABSORB_LOADER_BYTESWAP_EN
        check("bytes3_blocks", blocks, {96'd0, 32'h04030200});
`else
        check("bytes3_blocks", blocks, {96'd0, 32'h00020304});
`endif
        check("bytes3_bytes", blk_bytes, 5'd3);
        take();

        // Oversize in_bytes saturates to a full word.
        send(32'hDEADBEEF, 1'b1, 3'd7);
`ifdef ABSORB_LOADER_BYTESWAP_EN
        check("sat_blocks", blocks, {96'd0, 32'hEFBEADDE});
`else
        check("sat_blocks", blocks, {96'd0, 32'hDEADBEEF});
`endif
        check("sat_bytes", blk_bytes, 5'd4);
        check("sat_partial", partial, 1'b1);
        take();

        // Multi-block message with downstream stall.
        cfg_domain = 2'd2;
        send(32'hA0000001, 1'b0, 3'd0);
        cfg_domain = 2'd1;
        send(32'hA0000002, 1'b0, 3'd0);
        send(32'hA0000003, 1'b0, 3'd0);
        send(32'hA0000004, 1'b0, 3'd0);
        held = blocks;
        check("mb1_blocks", held, 128'hA0000004_A0000003_A0000002_A0000001);
        in_data  = 32'hFFFFFFFF;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mb1_stall_ready", in_ready, 1'b0);
            check("mb1_stall_valid", blk_valid, 1'b1);
            check("mb1_stall_blocks", blocks, held);
            check("mb1_stall_final", finalize, 1'b0);
            check("mb1_stall_bytes", blk_bytes, 5'd16);
            check("mb1_stall_domain", domain, 2'd2);
        end
        in_valid = 1'b0;
        take();
        cfg_domain = 2'd2;
        send(32'hB0000005, 1'b0, 3'd0);
        cfg_domain = 2'd1;
        blk_ready = 1'b1;
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
        check("fill_ready_ignored", blk_bytes, 5'd4);
        check("fill_ready_inready", in_ready, 1'b1);
        send(32'hB0000006, 1'b1, 3'd4);
        check("mb2_blocks", blocks, {64'd0, 32'hB0000006, 32'hB0000005});
        check("mb2_final", finalize, 1'b1);
        check("mb2_bytes", blk_bytes, 5'd8);
        check("mb2_domain", domain, 2'd2);
        check("mb2_partial", partial, 1'b1);
        take();

        // Empty message.
        cfg_domain = 2'd3;
        send(32'hCAFEBABE, 1'b1, 3'd0);
        check("empty_valid", blk_valid, 1'b1);
        check("empty_blocks", blocks, 128'd0);
        check("empty_bytes", blk_bytes, 5'd0);
        check("empty_partial", partial, 1'b1);
        check("empty_final", finalize, 1'b1);
        check("empty_domain", domain, 2'd3);
        take();

        // Reset mid-fill discards the partial buffer.
        send(32'hDEAD0001, 1'b0, 3'd0);
        send(32'hDEAD0002, 1'b0, 3'd0);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid_valid", blk_valid, 1'b0);
        check("rstmid_blocks", blocks, 128'd0);
        check("rstmid_bytes", blk_bytes, 5'd0);
        check("rstmid_domain", domain, 2'd0);
        @(negedge clk);
        reset = 1'b0;
        check("rstmid_no_valid", blk_valid, 1'b0);
        send(32'h0000000A, 1'b0, 3'd0);
        send(32'h0000000B, 1'b0, 3'd0);
        send(32'h0000000C, 1'b0, 3'd0);
        send(32'h0000000D, 1'b0, 3'd0);
        check("rstmid_blk_valid", blk_valid, 1'b1);
        check("rstmid_blk", blocks, 128'h0000000D_0000000C_0000000B_0000000A);
        check("rstmid_final", finalize, 1'b0);
        check("rstmid_full_bytes", blk_bytes, 5'd16);
        take();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
